// File: rtl/case_1_mul_pipe_sat.sv
`default_nettype none
// ============================================================================
// Module      : case_1_mul_pipe_sat
// Description : Pipelined multiplier with valid/ready handshake. Each operand
//               may be signed or unsigned per transaction. The full-precision
//               product is rounded half-up, shifted right by SHIFT, then
//               saturated or wrapped to dout_WIDTH. The whole pipe advances
//               on a single clock enable, so downstream stalls are tolerated.
// Revision    : 1.0 - initial release
// ============================================================================
module case_1_mul_pipe_sat #(
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 16,
  parameter int NUM_STAGE  = 3,
  parameter int SHIFT      = 8,
  parameter int SAT        = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  din0_signed,
  input  logic                  din1_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  // Full product width: both operands carry one extra bit for signedness.
  localparam int c_P  = din0_WIDTH + din1_WIDTH + 2;
  // Working width for round/shift: wide enough that the rounding add cannot
  // overflow and that the fit test always has at least one discarded bit.
  localparam int c_SW = ((c_P + 1 > dout_WIDTH) ? c_P + 1 : dout_WIDTH) + 1;

  logic                   w_ce;
  logic [NUM_STAGE-1:0]   r_vld;
  logic signed [c_P-1:0]  w_ax;
  logic signed [c_P-1:0]  w_bx;
  logic signed [c_P-1:0]  w_prod;
  logic signed [c_P-1:0]  w_src;
  logic signed [c_SW-1:0] w_ext;
  logic signed [c_SW-1:0] w_rnd;
  logic signed [c_SW-1:0] w_shf;
  logic [c_SW-dout_WIDTH:0] w_hi;
  logic                   w_fits;
  logic [dout_WIDTH-1:0]  w_dout;
  logic [dout_WIDTH-1:0]  r_dout;
  logic                   r_ovf;

  // One enable for the whole pipe: move whenever the output slot is free or drained.
  assign w_ce      = out_ready | ~r_vld[NUM_STAGE-1];
  assign in_ready  = w_ce;
  assign out_valid = r_vld[NUM_STAGE-1];
  assign dout      = r_dout;
  assign ovf       = r_ovf;

  // Operand extension: the mode bit decides whether the MSB is replicated.
  assign w_ax   = {{(c_P - din0_WIDTH){din0_signed & din0[din0_WIDTH-1]}}, din0};
  assign w_bx   = {{(c_P - din1_WIDTH){din1_signed & din1[din1_WIDTH-1]}}, din1};
  assign w_prod = w_ax * w_bx;

  // Valid bits shift along with the data; a bubble is just a 0 here.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_vld <= '0;
    end else if (w_ce) begin
      r_vld[0] <= in_valid;
      for (int i = 1; i < NUM_STAGE; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  // Product registers: stage 0 holds the multiply, later ones balance latency.
  // Mode bits are fully consumed by the multiply, so only the product travels.
  generate
    if (NUM_STAGE > 1) begin : g_prod_pipe
      logic signed [c_P-1:0] r_p [NUM_STAGE-1];

      // Register the product and carry it through the balance stages.
      always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
          for (int i = 0; i < NUM_STAGE - 1; i++) begin
            r_p[i] <= '0;
          end
        end else if (w_ce) begin
          r_p[0] <= w_prod;
          for (int i = 1; i < NUM_STAGE - 1; i++) begin
            r_p[i] <= r_p[i-1];
          end
        end
      end

      assign w_src = r_p[NUM_STAGE-2];
    end else begin : g_prod_direct
      assign w_src = w_prod;
    end
  endgenerate

  assign w_ext = {{(c_SW - c_P){w_src[c_P-1]}}, w_src};

  // Add half an LSB of the shifted result, so the floor-shift rounds half up.
  generate
    if (SHIFT > 0) begin : g_round
      localparam logic [c_SW-1:0] c_HALF = {{(c_SW-1){1'b0}}, 1'b1} << (SHIFT - 1);
      assign w_rnd = w_ext + $signed(c_HALF);
    end else begin : g_no_round
      assign w_rnd = w_ext;
    end
  endgenerate

  assign w_shf  = w_rnd >>> SHIFT;
  // The result fits iff every bit from the dout sign bit upward agrees.
  assign w_hi   = w_shf[c_SW-1:dout_WIDTH-1];
  assign w_fits = (&w_hi) | ~(|w_hi);

  // Clamp toward the sign of the true value, or just keep the low bits.
  always_comb begin
    w_dout = w_shf[dout_WIDTH-1:0];
    if ((SAT != 0) && !w_fits) begin
      w_dout = w_shf[c_SW-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                             : {1'b0, {(dout_WIDTH-1){1'b1}}};
    end
  end

  // Output stage: holds while the downstream stalls.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_dout <= '0;
      r_ovf  <= 1'b0;
    end else if (w_ce) begin
      r_dout <= w_dout;
      r_ovf  <= ~w_fits;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_case_1_mul_pipe_sat.sv
`default_nettype none
// ============================================================================
// Module      : tb_case_1_mul_pipe_sat
// Description : Scoreboard bench for case_1_mul_pipe_sat with default
//               parameters: directed vectors, backpressure, mid-stream reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_case_1_mul_pipe_sat;

  typedef struct {
    logic [15:0] d;
    logic        o;
    int          acc;
    bit          lat;
  } exp_t;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] din0;
  logic [11:0] din1;
  logic        din0_signed;
  logic        din1_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
  logic        ovf;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t q[$];

  case_1_mul_pipe_sat dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .din0        (din0),
    .din1        (din1),
    .din0_signed (din0_signed),
    .din1_signed (din1_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dout        (dout),
    .ovf         (ovf)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every output handshake.
  always @(negedge ap_clk) begin
    if (ap_rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_output: got dout=%0h with empty scoreboard", dout);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("dout", {16'h0, dout}, {16'h0, e.d});
        chk("ovf", {31'h0, ovf}, {31'h0, e.o});
        if (e.lat) chk("latency", cyc - e.acc, 3);
      end
    end
  end

  // Present one transaction and wait (bounded) for it to be accepted.
  task automatic send(input logic [13:0] a, input logic [11:0] b, input logic sa,
                      input logic sb, input logic [15:0] ed, input logic eo,
                      input bit lat);
    bit acc = 0;
    int n   = 0;
    int ac  = 0;
    din0 = a; din1 = b; din0_signed = sa; din1_signed = sb; in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge ap_clk);
      acc = (in_ready === 1'b1);
      ac  = cyc;
      @(posedge ap_clk);
      #1;
      n++;
    end
    if (acc) begin
      exp_t e;
      e.d = ed; e.o = eo; e.acc = ac; e.lat = lat;
      q.push_back(e);
    end else begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1");
    end
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected result has been delivered.
  task automatic drain;
    int n = 0;
    while ((q.size() != 0 || out_valid === 1'b1) && n < 200) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    ap_rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    din0 = '0; din1 = '0; din0_signed = 1'b0; din1_signed = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_dout", {16'h0, dout}, 0);
    chk("rst_ovf", {31'h0, ovf}, 0);
    chk("rst_in_ready", {31'h0, in_ready}, 1);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;

    // Signed product with latency check, then saturation both ways.
    send(14'h3F00, 12'd7, 1, 1, 16'hFFF9, 0, 1);
    drain();
    send(14'd8191, 12'd2047, 1, 1, 16'h7FFF, 1, 0);
    send(14'h2000, 12'd2047, 1, 1, 16'h8000, 1, 0);
    // Same bits, different signedness.
    send(14'h3FFF, 12'd1, 0, 0, 16'h0040, 0, 0);
    send(14'h3FFF, 12'd1, 1, 1, 16'h0000, 0, 0);
    // Rounding boundary: exactly half rounds up, just below rounds down.
    send(14'd1, 12'd128, 1, 1, 16'h0001, 0, 0);
    send(14'd1, 12'd127, 1, 1, 16'h0000, 0, 0);
    drain();

    // Backpressure: five back-to-back tokens, output held for four cycles.
    out_ready = 1'b0;
    fork
      begin
        send(14'd1,    12'd128,   1, 1, 16'h0001, 0, 0);
        send(14'd512,  12'd3,     1, 1, 16'h0006, 0, 0);
        send(14'h3E00, 12'd3,     1, 1, 16'hFFFA, 0, 0);
        send(14'h3E00, 12'd3,     0, 1, 16'h00BA, 0, 0);
        send(14'd100,  12'hFFF,   1, 0, 16'h0640, 0, 0);
      end
      begin
        int k = 0;
        do begin
          @(negedge ap_clk);
          k++;
        end while (out_valid !== 1'b1 && k < 50);
        for (int i = 0; i < 4; i++) begin
          if (i > 0) @(negedge ap_clk);
          chk("stall_out_valid", {31'h0, out_valid}, 1);
          chk("stall_dout", {16'h0, dout}, {16'h0, 16'h0001});
          chk("stall_in_ready", {31'h0, in_ready}, 0);
        end
        @(posedge ap_clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three tokens in flight: none of them may come out.
    out_ready = 1'b0;
    send(14'd8191, 12'd2047, 1, 1, 16'h7FFF, 1, 0);
    send(14'd512,  12'd3,    1, 1, 16'h0006, 0, 0);
    send(14'd1,    12'd128,  1, 1, 16'h0001, 0, 0);
    ap_rst_n = 1'b0;
    q.delete();
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("mrst_out_valid", {31'h0, out_valid}, 0);
    chk("mrst_dout", {16'h0, dout}, 0);
    chk("mrst_in_ready", {31'h0, in_ready}, 1);
    @(posedge ap_clk);
    #1;
    out_ready = 1'b1;
    repeat (6) @(posedge ap_clk);
    #1;
    send(14'h3F00, 12'd7, 1, 1, 16'hFFF9, 0, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
